vga_scanout: RTL and testbench



---
 rtl/vga_scanout.sv | 119 +++++++++++
 tb/tb_vga_scanout.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/vga_scanout.sv
// 640x480@60 Hz scan-out engine: divides the system clock down to a pixel tick,
// walks the raster, streams video-memory read addresses and registers RGB/sync pins.
module vga_scanout #(
  parameter int CLOCK_DIV  = 2,
  parameter int ADDR_WIDTH = 24,
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [2:0]            iPixelData,
  output logic [ADDR_WIDTH-1:0] oReadAddress,
  output logic                  oVGA_RED,
  output logic                  oVGA_GREEN,
  output logic                  oVGA_BLUE,
  output logic                  oVGA_HSYNC,
  output logic                  oVGA_VSYNC,
  output logic                  oFrameStart
);

  localparam int HTOTAL    = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int VTOTAL    = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W     = (CLOCK_DIV > 1) ? $clog2(CLOCK_DIV) : 1;
  localparam int H_W       = $clog2(HTOTAL);
  localparam int V_W       = $clog2(VTOTAL);
  localparam int HS_START  = H_VISIBLE + H_FRONT;
  localparam int HS_END    = HS_START + H_SYNC;
  localparam int VS_START  = V_VISIBLE + V_FRONT;
  localparam int VS_END    = VS_START + V_SYNC;
  localparam int LAST_ADDR = H_VISIBLE * V_VISIBLE - 1;

  logic [DIV_W-1:0]      div_q, div_d;
  logic [H_W-1:0]        hcount_q, hcount_d;
  logic [V_W-1:0]        vcount_q, vcount_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [2:0]            rgb_q, rgb_d;
  logic                  hsync_q, hsync_d;
  logic                  vsync_q, vsync_d;
  logic                  frameStart_q, frameStart_d;
  logic                  started_q, started_d;
  logic                  tick, hWrap, vWrap, visible;

  always_comb begin
    tick    = (div_q == DIV_W'(CLOCK_DIV - 1));
    div_d   = tick ? '0 : div_q + DIV_W'(1);
    hWrap   = (hcount_q == H_W'(HTOTAL - 1));
    vWrap   = (vcount_q == V_W'(VTOTAL - 1));
    visible = (hcount_q < H_W'(H_VISIBLE)) && (vcount_q < V_W'(V_VISIBLE));
  end

  // The address only advances past visible pixels, so in blanking it already
  // points at the first pixel of the next visible line.
  always_comb begin
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    addr_d   = addr_q;
    if (tick) begin
      hcount_d = hWrap ? '0 : hcount_q + H_W'(1);
      if (hWrap) begin
        vcount_d = vWrap ? '0 : vcount_q + V_W'(1);
      end
      if (visible) begin
        addr_d = (addr_q == ADDR_WIDTH'(LAST_ADDR)) ? '0 : addr_q + ADDR_WIDTH'(1);
      end
    end
  end

  always_comb begin
    rgb_d        = rgb_q;
    hsync_d      = hsync_q;
    vsync_d      = vsync_q;
    started_d    = started_q | tick;
    frameStart_d = tick && (hcount_q == '0) && (vcount_q == '0) && started_q;
    if (tick) begin
      rgb_d   = visible ? iPixelData : 3'b000;
      hsync_d = !((hcount_q >= H_W'(HS_START)) && (hcount_q < H_W'(HS_END)));
      vsync_d = !((vcount_q >= V_W'(VS_START)) && (vcount_q < V_W'(VS_END)));
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      div_q        <= '0;
      hcount_q     <= '0;
      vcount_q     <= '0;
      addr_q       <= '0;
      rgb_q        <= 3'b000;
      hsync_q      <= 1'b1;
      vsync_q      <= 1'b1;
      frameStart_q <= 1'b0;
      started_q    <= 1'b0;
    end else begin
      div_q        <= div_d;
      hcount_q     <= hcount_d;
      vcount_q     <= vcount_d;
      addr_q       <= addr_d;
      rgb_q        <= rgb_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      frameStart_q <= frameStart_d;
      started_q    <= started_d;
    end
  end

  assign oReadAddress = addr_q;
  assign oVGA_RED     = rgb_q[2];
  assign oVGA_GREEN   = rgb_q[1];
  assign oVGA_BLUE    = rgb_q[0];
  assign oVGA_HSYNC   = hsync_q;
  assign oVGA_VSYNC   = vsync_q;
  assign oFrameStart  = frameStart_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: a full-size instance and a shrunken-raster instance share
// clock/reset and are compared every clock against an arithmetic raster model.
module tb_vga_scanout;

  typedef struct {
    int div;
    int hv, hf, hs, hb;
    int vv, vf, vs, vb;
  } timing_t;

  localparam int SMALL_VIS = 8 * 6;

  timing_t tBig   = '{2, 640, 16, 96, 48, 480, 10, 2, 33};
  timing_t tSmall = '{3, 8, 2, 3, 2, 6, 1, 2, 1};

  logic        Clock;
  logic        Reset;
  logic [2:0]  pixBig, pixSmall;
  logic [23:0] addrBig;
  logic [7:0]  addrSmall;
  logic        redBig, greenBig, blueBig, hsBig, vsBig, fsBig;
  logic        redSmall, greenSmall, blueSmall, hsSmall, vsSmall, fsSmall;

  logic [2:0]  memSmall [SMALL_VIS];
  bit          dataMode;
  int          n;
  int          checkCount;
  int          passCount;

  vga_scanout dutBig (
    .Clock        (Clock),
    .Reset        (Reset),
    .iPixelData   (pixBig),
    .oReadAddress (addrBig),
    .oVGA_RED     (redBig),
    .oVGA_GREEN   (greenBig),
    .oVGA_BLUE    (blueBig),
    .oVGA_HSYNC   (hsBig),
    .oVGA_VSYNC   (vsBig),
    .oFrameStart  (fsBig)
  );

  vga_scanout #(
    .CLOCK_DIV(3), .ADDR_WIDTH(8),
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
  ) dutSmall (
    .Clock        (Clock),
    .Reset        (Reset),
    .iPixelData   (pixSmall),
    .oReadAddress (addrSmall),
    .oVGA_RED     (redSmall),
    .oVGA_GREEN   (greenSmall),
    .oVGA_BLUE    (blueSmall),
    .oVGA_HSYNC   (hsSmall),
    .oVGA_VSYNC   (vsSmall),
    .oFrameStart  (fsSmall)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic logic [2:0] pixelAt(input bit big, input int a);
    logic [31:0] av;
    av = a;
    if (dataMode) return 3'b111;
    if (big) return av[2:0];
    return memSmall[a];
  endfunction

  // After n clocks from reset release, k = n/div ticks have happened: counters sit
  // on raster position k and the pins show position k-1.
  function automatic void model(input timing_t t, input int clocks, input bit big,
                                output logic [31:0] eAddr, output logic [2:0] eRgb,
                                output logic eHs, output logic eVs, output logic eFs);
    int ht, vt, total, vis, k, pos, h, v, p, ph, pv;
    ht    = t.hv + t.hf + t.hs + t.hb;
    vt    = t.vv + t.vf + t.vs + t.vb;
    total = ht * vt;
    vis   = t.hv * t.vv;
    k     = clocks / t.div;
    if (k == 0) begin
      eAddr = 0; eRgb = 3'b000; eHs = 1'b1; eVs = 1'b1; eFs = 1'b0;
      return;
    end
    pos   = k % total;
    h     = pos % ht;
    v     = pos / ht;
    eAddr = (v < t.vv) ? (v * t.hv + ((h < t.hv) ? h : t.hv)) % vis : 0;
    p     = (k - 1) % total;
    ph    = p % ht;
    pv    = p / ht;
    eRgb  = (ph < t.hv && pv < t.vv) ? pixelAt(big, pv * t.hv + ph) : 3'b000;
    eHs   = !(ph >= t.hv + t.hf && ph < t.hv + t.hf + t.hs);
    eVs   = !(pv >= t.vv + t.vf && pv < t.vv + t.vf + t.vs);
    eFs   = (clocks % t.div == 0) && (p == 0) && (k > 1);
  endfunction

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount = passCount + 1;
    else $error("[TB] FAIL %s at clock %0d: observed %0h, expected %0h", tag, n, obs, exp);
  endtask

  task automatic checkOutput();
    logic [31:0] eAddr;
    logic [2:0]  eRgb;
    logic        eHs, eVs, eFs;
    model(tBig, n, 1'b1, eAddr, eRgb, eHs, eVs, eFs);
    checkValue("big.addr",   addrBig, eAddr);
    checkValue("big.rgb",    {redBig, greenBig, blueBig}, eRgb);
    checkValue("big.hsync",  hsBig, eHs);
    checkValue("big.vsync",  vsBig, eVs);
    checkValue("big.frame",  fsBig, eFs);
    model(tSmall, n, 1'b0, eAddr, eRgb, eHs, eVs, eFs);
    checkValue("small.addr",  addrSmall, eAddr);
    checkValue("small.rgb",   {redSmall, greenSmall, blueSmall}, eRgb);
    checkValue("small.hsync", hsSmall, eHs);
    checkValue("small.vsync", vsSmall, eVs);
    checkValue("small.frame", fsSmall, eFs);
    // Memory answers the current address well before the next tick samples it.
    pixBig   = dataMode ? 3'b111 : addrBig[2:0];
    pixSmall = dataMode ? 3'b111 :
               ((int'(addrSmall) < SMALL_VIS) ? memSmall[addrSmall] : 3'b000);
  endtask

  task automatic applyStimulus(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge Clock);
      n++;
      @(negedge Clock);
      checkOutput();
    end
  endtask

  task automatic refillMemory(input bit forced);
    dataMode = forced;
    for (int i = 0; i < SMALL_VIS; i++) memSmall[i] = 3'($urandom_range(0, 7));
  endtask

  // Reset lands between clock edges; the pins must already show reset values.
  task automatic asyncReset(input bit forced);
    @(negedge Clock);
    #2 Reset = 1'b1;
    #1 n = 0;
    checkOutput();
    refillMemory(forced);
    repeat (3) begin
      @(negedge Clock);
      checkOutput();
    end
    Reset = 1'b0;
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    n          = 0;
    pixBig     = 3'b000;
    pixSmall   = 3'b000;
    Reset      = 1'b1;
    refillMemory(1'b0);
    repeat (4) begin
      @(negedge Clock);
      checkOutput();
    end
    Reset = 1'b0;
    applyStimulus(3300 + $urandom_range(0, 400));
    asyncReset(1'b1);
    applyStimulus(3400);
    asyncReset(1'b0);
    applyStimulus(1000 + $urandom_range(0, 300));
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
